moore_step_ctrl: RTL and testbench

Sequencer that drives a small Moore FSM under test (state-load reset, step enable, switch input) through a programmed vector table. After each step it compares the FSM's state and output against expected values. It sits between a host/testbench register interface and one FSM instance. It reports pass/fail, an error count and the first failing vector index.

---
 rtl/moore_step_ctrl.sv | 178 +++++++++++++++++
 tb/tb_moore_step_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/moore_step_ctrl.sv
// ---------------------------------------------------------------------------
// moore_step_ctrl
//   Walks a small Moore FSM under test through a programmed vector table.
//   Each vector is one STEP cycle (step enable + switch value), then one CHECK
//   cycle that compares the FSM's state/output with the expected values.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  run request (IDLE only)
//   init_state             state loaded into the FSM at run start
//   num_vec                vectors to run, clamped to DEPTH
//   stop_on_err            end the run at the first mismatch
//   wr_en/wr_addr/wr_*     vector table write port (ignored while busy)
//   fsm_reset              state-load pulse to the FSM
//   fsm_state_in           value loaded by fsm_reset
//   fsm_ctrl, fsm_sw       FSM step enable and switch input
//   fsm_state, fsm_out     FSM current state and registered output
//   busy, done, pass       run status
//   err_cnt                saturating mismatch count of the last run
//   first_err_valid/_idx   first failing vector of the last run
// ---------------------------------------------------------------------------
module moore_step_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int SW_W  = 2,
    parameter int ST_W  = 3,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [ST_W-1:0] init_state,
    input  logic [AW:0]     num_vec,
    input  logic            stop_on_err,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [SW_W-1:0] wr_sw,
    input  logic [ST_W-1:0] wr_exp_state,
    input  logic            wr_exp_out,
    output logic            fsm_reset,
    output logic [ST_W-1:0] fsm_state_in,
    output logic            fsm_ctrl,
    output logic [SW_W-1:0] fsm_sw,
    input  logic [ST_W-1:0] fsm_state,
    input  logic            fsm_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_cnt,
    output logic            first_err_valid,
    output logic [AW-1:0]   first_err_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [AW:0]     L_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]     L_NUM_ONE = 1;
    localparam logic [AW-1:0]   L_IDX_ONE = 1;
    localparam logic [ERRW-1:0] L_ERR_ONE = 1;

    // Vector table: not reset, written only while idle.
    logic [SW_W-1:0] r_tab_sw  [DEPTH];
    logic [ST_W-1:0] r_tab_st  [DEPTH];
    logic            r_tab_out [DEPTH];

    logic [2:0]      r_state;
    logic [AW-1:0]   r_idx;
    logic [AW:0]     r_num;
    logic            r_stop;
    logic [ST_W-1:0] r_init;
    logic [SW_W-1:0] r_sw;
    logic            r_pass;
    logic [ERRW-1:0] r_err;
    logic            r_fev;
    logic [AW-1:0]   r_fei;

    logic            w_busy;
    logic [AW:0]     w_num_clamp;
    logic            w_mis;
    logic            w_last;
    logic [AW-1:0]   w_idx_nx;
    logic [ERRW-1:0] w_err_inc;

    assign w_busy      = (r_state == S_LOAD) || (r_state == S_STEP) || (r_state == S_CHECK);
    assign w_num_clamp = (num_vec > L_DEPTH) ? L_DEPTH : num_vec;
    assign w_mis       = (fsm_state != r_tab_st[r_idx]) || (fsm_out != r_tab_out[r_idx]);
    assign w_last      = ({1'b0, r_idx} == (r_num - L_NUM_ONE));
    assign w_idx_nx    = r_idx + L_IDX_ONE;
    assign w_err_inc   = (r_err == '1) ? r_err : (r_err + L_ERR_ONE);

    always_ff @(posedge clk) begin
        if (wr_en && !w_busy) begin
            r_tab_sw[wr_addr]  <= wr_sw;
            r_tab_st[wr_addr]  <= wr_exp_state;
            r_tab_out[wr_addr] <= wr_exp_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_num   <= '0;
            r_stop  <= 1'b0;
            r_init  <= '0;
            r_sw    <= '0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fev   <= 1'b0;
            r_fei   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_init  <= init_state;
                        r_num   <= w_num_clamp;
                        r_stop  <= stop_on_err;
                        r_err   <= '0;
                        r_fev   <= 1'b0;
                        r_fei   <= '0;
                        r_pass  <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_num == '0) begin
                        r_pass  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= '0;
                        r_sw    <= r_tab_sw[0];
                        r_state <= S_STEP;
                    end
                end
                S_STEP: r_state <= S_CHECK;
                S_CHECK: begin
                    if (w_mis) begin
                        r_err <= w_err_inc;
                        if (!r_fev) begin
                            r_fev <= 1'b1;
                            r_fei <= r_idx;
                        end
                    end
                    if (w_last || (w_mis && r_stop)) begin
                        // pass is visible in the DONE cycle alongside done
                        r_pass  <= !w_mis && !r_fev;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= w_idx_nx;
                        // fsm_sw only changes on entry to STEP, so it holds elsewhere
                        r_sw    <= r_tab_sw[w_idx_nx];
                        r_state <= S_STEP;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Moore decode from the state register: the async reset forces IDLE,
    // so every strobe drops the instant reset_n falls.
    assign fsm_reset       = (r_state == S_LOAD);
    assign fsm_ctrl        = (r_state == S_STEP);
    assign done            = (r_state == S_DONE);
    assign busy            = w_busy;
    assign fsm_state_in    = r_init;
    assign fsm_sw          = r_sw;
    assign pass            = r_pass;
    assign err_cnt         = r_err;
    assign first_err_valid = r_fev;
    assign first_err_idx   = r_fei;

endmodule

// File: tb/tb_moore_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_moore_step_ctrl
//   Directed + randomized runs of moore_step_ctrl driving a behavioural Moore
//   FSM (state bit0 toggles on a step with a nonzero switch; output = state[0],
//   optionally inverted). A second instance with ERRW=2 shares all inputs and
//   is used to check error-count saturation.
//   Latency is counted as the number of clock edges from the edge that samples
//   start to the first edge that samples done high.
// ---------------------------------------------------------------------------
module tb_moore_step_ctrl;
    localparam int DEPTH = 16, AW = 4, SW_W = 2, ST_W = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            start = 0, stop_on_err = 0, wr_en = 0, wr_exp_out = 0;
    logic [ST_W-1:0] init_state = '0, wr_exp_state = '0;
    logic [AW:0]     num_vec = '0;
    logic [AW-1:0]   wr_addr = '0;
    logic [SW_W-1:0] wr_sw = '0;

    logic            fsm_reset, fsm_ctrl, busy, done, pass, fev;
    logic [ST_W-1:0] fsm_state_in;
    logic [SW_W-1:0] fsm_sw;
    logic [7:0]      err_cnt;
    logic [AW-1:0]   fei;

    logic            b_fsm_reset, b_fsm_ctrl, b_busy, b_done, b_pass, b_fev;
    logic [ST_W-1:0] b_fsm_state_in;
    logic [SW_W-1:0] b_fsm_sw;
    logic [1:0]      b_err_cnt;
    logic [AW-1:0]   b_fei;

    // behavioural FSM under test
    logic [ST_W-1:0] f_st = '0;
    logic            f_out = 1'b0;
    logic            inv = 1'b0;

    always @(posedge clk) begin
        if (fsm_reset) begin
            f_st  <= fsm_state_in;
            f_out <= fsm_state_in[0] ^ inv;
        end else if (fsm_ctrl) begin
            f_st  <= f_st ^ {2'b00, (fsm_sw != 0)};
            f_out <= (f_st[0] ^ (fsm_sw != 0)) ^ inv;
        end
    end

    moore_step_ctrl u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .init_state(init_state),
        .num_vec(num_vec), .stop_on_err(stop_on_err), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_sw(wr_sw), .wr_exp_state(wr_exp_state),
        .wr_exp_out(wr_exp_out), .fsm_reset(fsm_reset), .fsm_state_in(fsm_state_in),
        .fsm_ctrl(fsm_ctrl), .fsm_sw(fsm_sw), .fsm_state(f_st), .fsm_out(f_out),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_valid(fev), .first_err_idx(fei)
    );

    moore_step_ctrl #(.ERRW(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .start(start), .init_state(init_state),
        .num_vec(num_vec), .stop_on_err(stop_on_err), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_sw(wr_sw), .wr_exp_state(wr_exp_state),
        .wr_exp_out(wr_exp_out), .fsm_reset(b_fsm_reset), .fsm_state_in(b_fsm_state_in),
        .fsm_ctrl(b_fsm_ctrl), .fsm_sw(b_fsm_sw), .fsm_state(f_st), .fsm_out(f_out),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err_cnt),
        .first_err_valid(b_fev), .first_err_idx(b_fei)
    );

    // reference copy of the table
    int m_sw [DEPTH];
    int m_st [DEPTH];
    int m_out[DEPTH];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int sw, input int st, input int o);
        @(negedge clk);
        wr_en = 1; wr_addr = a[AW-1:0]; wr_sw = sw[SW_W-1:0];
        wr_exp_state = st[ST_W-1:0]; wr_exp_out = o[0];
        m_sw[a] = sw; m_st[a] = st; m_out[a] = o;
        @(negedge clk);
        wr_en = 0;
    endtask

    // Reference: walk the vectors with plain arithmetic.
    task automatic model(input int init, input int nv, input int stop,
                         output int e_err, output int e_fev, output int e_fei,
                         output int e_pass, output int e_steps);
        int n, s, o;
        bit mis;
        n = (nv > DEPTH) ? DEPTH : nv;
        s = init; e_err = 0; e_fev = 0; e_fei = 0; e_steps = 0;
        for (int i = 0; i < n; i++) begin
            if (m_sw[i] != 0) s = s ^ 1;
            o = (s & 1) ^ int'(inv);
            e_steps++;
            mis = (s != m_st[i]) || (o != m_out[i]);
            if (mis) begin
                e_err++;
                if (e_fev == 0) begin e_fev = 1; e_fei = i; end
                if (stop != 0) break;
            end
        end
        e_pass = (e_err == 0) ? 1 : 0;
    endtask

    task automatic run(input string nm, input int init, input int nv, input int stop, input bit inject);
        int e_err, e_fev, e_fei, e_pass, e_steps, lat, n_ctrl, n_rst;
        bit seen;
        model(init, nv, stop, e_err, e_fev, e_fei, e_pass, e_steps);
        @(negedge clk);
        start = 1; init_state = init[ST_W-1:0]; num_vec = nv[AW:0]; stop_on_err = stop[0];
        @(posedge clk);
        #1 start = 0;
        seen = 0; lat = 0; n_ctrl = 0; n_rst = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (inject && k == 2) begin
                // illegal while busy: must neither restart nor write
                start = 1; wr_en = 1; wr_addr = '0;
                wr_sw = ~m_sw[0][SW_W-1:0]; wr_exp_state = ~m_st[0][ST_W-1:0];
                wr_exp_out = ~m_out[0][0];
            end else if (inject && k == 3) begin
                start = 0; wr_en = 0;
            end
            if (fsm_ctrl) n_ctrl++;
            if (fsm_reset) begin
                n_rst++;
                chk({nm, " state_in"}, 32'(fsm_state_in), 32'(init & 7));
            end
            if (done) begin seen = 1; lat = k + 1; break; end
        end
        chk({nm, " done_seen"}, 32'(seen), 1);
        chk({nm, " latency"}, lat, 2 * e_steps + 2);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " pass"}, 32'(pass), e_pass);
        chk({nm, " err_cnt"}, 32'(err_cnt), e_err);
        chk({nm, " err_cnt_sat"}, 32'(b_err_cnt), (e_err > 3) ? 3 : e_err);
        chk({nm, " fev"}, 32'(fev), e_fev);
        chk({nm, " fei"}, 32'(fei), e_fei);
        chk({nm, " n_ctrl"}, n_ctrl, e_steps);
        chk({nm, " n_rst"}, n_rst, 1);
        @(negedge clk);
        chk({nm, " done_pulse"}, 32'(done), 0);
        chk({nm, " pass_hold"}, 32'(pass), e_pass);
    endtask

    initial begin
        int init, s, bad;
        bit seen;
        #12;
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst pass", 32'(pass), 0);
        chk("rst err_cnt", 32'(err_cnt), 0);
        chk("rst fev", 32'(fev), 0);
        chk("rst fei", 32'(fei), 0);
        chk("rst fsm_reset", 32'(fsm_reset), 0);
        chk("rst fsm_ctrl", 32'(fsm_ctrl), 0);
        chk("rst fsm_sw", 32'(fsm_sw), 0);
        chk("rst state_in", 32'(fsm_state_in), 0);
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < DEPTH; i++) begin m_sw[i] = 0; m_st[i] = 0; m_out[i] = 0; end
        wr(0, 1, 1, 1);
        wr(1, 0, 1, 1);
        wr(2, 3, 0, 0);
        wr(3, 2, 1, 1);

        inv = 0; run("golden", 0, 4, 0, 0);
        inv = 1; run("inverted", 0, 4, 0, 0);
        inv = 1; run("inv_stop", 0, 4, 1, 0);
        inv = 0; run("zero_vec", 1, 0, 0, 0);

        // async reset in the middle of a STEP cycle
        @(negedge clk);
        start = 1; init_state = '0; num_vec = 5'd4; stop_on_err = 0;
        @(posedge clk);
        #1 start = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (fsm_ctrl) seen = 1;
        end
        chk("mid step_seen", 32'(seen), 1);
        #2 reset_n = 0;
        #1;
        chk("mid busy", 32'(busy), 0);
        chk("mid fsm_ctrl", 32'(fsm_ctrl), 0);
        chk("mid fsm_reset", 32'(fsm_reset), 0);
        chk("mid done", 32'(done), 0);
        @(negedge clk);
        reset_n = 1;
        run("after_reset", 0, 4, 0, 0);

        run("inject", 0, 4, 0, 1);
        run("entry0_kept", 0, 4, 0, 0);

        wr(4, 1, 0, 0);
        inv = 0; run("golden5", 0, 5, 0, 0);
        inv = 1; run("sat5", 0, 5, 0, 0);

        // randomized tables, mostly self-consistent with a few corrupted entries
        for (int r = 0; r < 25; r++) begin
            init = int'($urandom_range(0, 7));
            s = init;
            for (int i = 0; i < DEPTH; i++) begin
                int sw, st, o;
                sw = int'($urandom_range(0, 3));
                if (sw != 0) s = s ^ 1;
                st = s; o = s & 1;
                bad = int'($urandom_range(0, 9));
                if (bad == 0) st = st ^ int'($urandom_range(1, 7));
                if (bad == 1) o = o ^ 1;
                wr(i, sw, st, o);
            end
            inv = ($urandom_range(0, 3) == 0);
            run("random", init, int'($urandom_range(0, 31)), int'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
